// File: rtl/cpu_trace_buffer.sv
// CPU instruction trace capture: samples {pc, instr} on PC change into a FIFO,
// counts overflow drops and freezes capture once the halt instruction is seen.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | not capturing; readout continues
//   CAPTURE | sampling PC_IN/INSTR_IN whenever the PC changes
//   HALTED  | halt instruction seen; capture frozen until RESET
module cpu_trace_buffer #(
   parameter int          DEPTH      = 16,
   parameter int          ADDR_W     = 4,
   parameter logic [31:0] HALT_INSTR = 32'h0000_006F
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              CAP_EN,
   input  logic [31:0]       PC_IN,
   input  logic [31:0]       INSTR_IN,
   output logic              OUT_VALID,
   input  logic              OUT_READY,
   output logic [63:0]       OUT_DATA,
   output logic [ADDR_W:0]   COUNT,
   output logic [15:0]       DROP_CNT,
   output logic              DONE
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] CAPTURE = 2'd1;
   localparam logic [1:0] HALTED  = 2'd2;

   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

   logic [1:0]        state_q, state_d;
   logic              first_q, first_d;
   logic [31:0]       last_pc_q, last_pc_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic [15:0]       drop_q, drop_d;
   logic [63:0]       mem_q [DEPTH];

   logic pop;
   logic sample;
   logic full;
   logic push;
   logic drop;
   logic halt_hit;

   always_comb begin
      pop      = (count_q != '0) && OUT_READY;
      sample   = (state_q == CAPTURE) && (first_q || (PC_IN != last_pc_q));
      full     = (count_q == FULL_CNT);
      push     = sample && (!full || pop);
      drop     = sample && full && !pop;
      halt_hit = sample && (INSTR_IN == HALT_INSTR);

      state_d   = state_q;
      first_d   = first_q;
      last_pc_d = last_pc_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      drop_d    = drop_q;

      case (state_q)
         IDLE: begin
            if (CAP_EN) begin
               state_d = CAPTURE;
               first_d = 1'b1;
            end
         end
         CAPTURE: begin
            // A halt sample wins even when it was dropped for lack of space
            if (halt_hit) begin
               state_d = HALTED;
            end else if (!CAP_EN) begin
               state_d = IDLE;
            end
         end
         HALTED:  state_d = HALTED;
         default: state_d = IDLE;
      endcase

      if (sample) begin
         first_d   = 1'b0;
         last_pc_d = PC_IN;
      end

      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !push) begin
         count_d = count_q - 1'b1;
      end

      if (drop && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q   <= IDLE;
         first_q   <= 1'b1;
         last_pc_q <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         drop_q    <= '0;
      end else begin
         state_q   <= state_d;
         first_q   <= first_d;
         last_pc_q <= last_pc_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         drop_q    <= drop_d;
      end
   end

   // Storage carries no reset; COUNT alone decides what is valid
   always_ff @(posedge CLK) begin
      if (push) mem_q[wr_ptr_q] <= {PC_IN, INSTR_IN};
   end

   assign OUT_VALID = (count_q != '0);
   assign OUT_DATA  = mem_q[rd_ptr_q];
   assign COUNT     = count_q;
   assign DROP_CNT  = drop_q;
   assign DONE      = (state_q == HALTED);

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Scenario bench for cpu_trace_buffer: expected trace entries are queued as
// stimulus is driven and compared in order as the consumer drains them.
module tb_cpu_trace_buffer;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic        CAP_EN = 1'b0;
   logic [31:0] PC_IN = '0;
   logic [31:0] INSTR_IN = '0;
   logic        OUT_VALID;
   logic        OUT_READY = 1'b0;
   logic [63:0] OUT_DATA;
   logic [4:0]  COUNT;
   logic [15:0] DROP_CNT;
   logic        DONE;

   int total = 0;
   int bad   = 0;
   logic [63:0] exp_q [$];

   cpu_trace_buffer #(.DEPTH(16), .ADDR_W(4), .HALT_INSTR(32'h0000_006F)) dut (
      .CLK(CLK), .RESET(RESET), .CAP_EN(CAP_EN), .PC_IN(PC_IN), .INSTR_IN(INSTR_IN),
      .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
      .COUNT(COUNT), .DROP_CNT(DROP_CNT), .DONE(DONE));

   always #5 CLK = ~CLK;

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RESET = 1'b1; CAP_EN = 1'b0; OUT_READY = 1'b0;
      cyc();
      RESET = 1'b0;
      exp_q.delete();
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (COUNT !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", COUNT); end
      total++; if (OUT_VALID !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", OUT_VALID); end
      total++; if (DONE !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", DONE); end
      total++; if (DROP_CNT !== 16'd0) begin bad++; $display("FAIL reset_drop got=%0d exp=0", DROP_CNT); end
   endtask

   task automatic test_basic();
      CAP_EN = 1'b1;
      cyc();
      total++; if (COUNT !== 5'd0) begin bad++; $display("FAIL basic_no_entry_sample got=%0d exp=0", COUNT); end
      PC_IN = 32'h0; INSTR_IN = 32'h13; exp_q.push_back({32'h0, 32'h13});
      cyc();
      total++; if (OUT_VALID !== 1'b1 || OUT_DATA !== 64'h0000_0000_0000_0013) begin
         bad++; $display("FAIL basic_head got=%b/%h exp=1/%h", OUT_VALID, OUT_DATA, 64'h13); end
      PC_IN = 32'h4; INSTR_IN = 32'h93;  exp_q.push_back({32'h4, 32'h93});  cyc();
      PC_IN = 32'h8; INSTR_IN = 32'h113; exp_q.push_back({32'h8, 32'h113}); cyc();
      total++; if (COUNT !== 5'd3) begin bad++; $display("FAIL basic_count got=%0d exp=3", COUNT); end
      CAP_EN = 1'b0;
      cyc();
      OUT_READY = 1'b1;
      for (int i = 0; i < 40 && exp_q.size() > 0; i++) begin
         total++; if (OUT_VALID !== 1'b1 || OUT_DATA !== exp_q[0]) begin
            bad++; $display("FAIL basic_drain got=%b/%h exp=1/%h", OUT_VALID, OUT_DATA, exp_q[0]); end
         void'(exp_q.pop_front());
         cyc();
      end
      OUT_READY = 1'b0;
      total++; if (COUNT !== 5'd0) begin bad++; $display("FAIL basic_empty got=%0d exp=0", COUNT); end
   endtask

   task automatic test_dup();
      CAP_EN = 1'b1;
      cyc();
      PC_IN = 32'h10; INSTR_IN = 32'h33;
      for (int i = 0; i < 5; i++) cyc();
      total++; if (COUNT !== 5'd1) begin bad++; $display("FAIL dup_count got=%0d exp=1", COUNT); end
      CAP_EN = 1'b0;
      cyc();
      // Re-entering capture with the same PC must still take a first sample
      CAP_EN = 1'b1;
      cyc();
      cyc();
      total++; if (COUNT !== 5'd2) begin bad++; $display("FAIL dup_first_flag got=%0d exp=2", COUNT); end
      CAP_EN = 1'b0;
      cyc();
      total++; if (OUT_DATA !== {32'h10, 32'h33}) begin
         bad++; $display("FAIL dup_data got=%h exp=%h", OUT_DATA, {32'h10, 32'h33}); end
   endtask

   task automatic test_overflow();
      do_reset();
      CAP_EN = 1'b1;
      cyc();
      for (int i = 0; i < 20; i++) begin
         PC_IN = 32'h100 + 32'(4 * i); INSTR_IN = 32'(i);
         if (i < 16) exp_q.push_back({PC_IN, INSTR_IN});
         cyc();
      end
      total++; if (COUNT !== 5'd16) begin bad++; $display("FAIL ovf_count got=%0d exp=16", COUNT); end
      total++; if (DROP_CNT !== 16'd4) begin bad++; $display("FAIL ovf_drop got=%0d exp=4", DROP_CNT); end
      CAP_EN = 1'b0;
      cyc();
      OUT_READY = 1'b1;
      for (int i = 0; i < 40 && exp_q.size() > 0; i++) begin
         total++; if (OUT_VALID !== 1'b1 || OUT_DATA !== exp_q[0]) begin
            bad++; $display("FAIL ovf_drain got=%b/%h exp=1/%h", OUT_VALID, OUT_DATA, exp_q[0]); end
         void'(exp_q.pop_front());
         cyc();
      end
      OUT_READY = 1'b0;
      total++; if (COUNT !== 5'd0 || DROP_CNT !== 16'd4) begin
         bad++; $display("FAIL ovf_after got=%0d/%0d exp=0/4", COUNT, DROP_CNT); end
   endtask

   task automatic test_full_pop();
      do_reset();
      CAP_EN = 1'b1;
      cyc();
      for (int i = 0; i < 16; i++) begin
         PC_IN = 32'h200 + 32'(4 * i); INSTR_IN = 32'h1000 + 32'(i);
         exp_q.push_back({PC_IN, INSTR_IN});
         cyc();
      end
      total++; if (OUT_DATA !== exp_q[0]) begin
         bad++; $display("FAIL fullpop_head got=%h exp=%h", OUT_DATA, exp_q[0]); end
      void'(exp_q.pop_front());
      OUT_READY = 1'b1; PC_IN = 32'h900; INSTR_IN = 32'hABCD;
      exp_q.push_back({PC_IN, INSTR_IN});
      cyc();
      OUT_READY = 1'b0; CAP_EN = 1'b0;
      total++; if (COUNT !== 5'd16) begin bad++; $display("FAIL fullpop_count got=%0d exp=16", COUNT); end
      total++; if (DROP_CNT !== 16'd0) begin bad++; $display("FAIL fullpop_drop got=%0d exp=0", DROP_CNT); end
      cyc();
      OUT_READY = 1'b1;
      for (int i = 0; i < 40 && exp_q.size() > 0; i++) begin
         total++; if (OUT_VALID !== 1'b1 || OUT_DATA !== exp_q[0]) begin
            bad++; $display("FAIL fullpop_drain got=%b/%h exp=1/%h", OUT_VALID, OUT_DATA, exp_q[0]); end
         void'(exp_q.pop_front());
         cyc();
      end
      OUT_READY = 1'b0;
      total++; if (COUNT !== 5'd0) begin bad++; $display("FAIL fullpop_empty got=%0d exp=0", COUNT); end
   endtask

   task automatic test_halt();
      do_reset();
      CAP_EN = 1'b1;
      cyc();
      PC_IN = 32'h20; INSTR_IN = 32'h13; exp_q.push_back({PC_IN, INSTR_IN}); cyc();
      total++; if (DONE !== 1'b0) begin bad++; $display("FAIL halt_early got=%b exp=0", DONE); end
      PC_IN = 32'h24; INSTR_IN = 32'h6F; exp_q.push_back({PC_IN, INSTR_IN}); cyc();
      total++; if (DONE !== 1'b1) begin bad++; $display("FAIL halt_done got=%b exp=1", DONE); end
      PC_IN = 32'h28; INSTR_IN = 32'h13; cyc();
      PC_IN = 32'h2C; cyc();
      CAP_EN = 1'b0; cyc();
      CAP_EN = 1'b1; PC_IN = 32'h30; cyc();
      cyc();
      total++; if (COUNT !== 5'd2 || DONE !== 1'b1) begin
         bad++; $display("FAIL halt_frozen got=%0d/%b exp=2/1", COUNT, DONE); end
      OUT_READY = 1'b1;
      for (int i = 0; i < 40 && exp_q.size() > 0; i++) begin
         total++; if (OUT_VALID !== 1'b1 || OUT_DATA !== exp_q[0]) begin
            bad++; $display("FAIL halt_drain got=%b/%h exp=1/%h", OUT_VALID, OUT_DATA, exp_q[0]); end
         void'(exp_q.pop_front());
         cyc();
      end
      OUT_READY = 1'b0;
      total++; if (COUNT !== 5'd0) begin bad++; $display("FAIL halt_empty got=%0d exp=0", COUNT); end
      do_reset();
      total++; if (DONE !== 1'b0 || COUNT !== 5'd0) begin
         bad++; $display("FAIL halt_reset got=%b/%0d exp=0/0", DONE, COUNT); end
   endtask

   task automatic test_halt_drop();
      do_reset();
      CAP_EN = 1'b1;
      cyc();
      for (int i = 0; i < 16; i++) begin
         PC_IN = 32'h400 + 32'(4 * i); INSTR_IN = 32'h13;
         cyc();
      end
      PC_IN = 32'h500; INSTR_IN = 32'h6F;
      cyc();
      total++; if (DONE !== 1'b1 || DROP_CNT !== 16'd1 || COUNT !== 5'd16) begin
         bad++; $display("FAIL halt_drop got=%b/%0d/%0d exp=1/1/16", DONE, DROP_CNT, COUNT); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      CAP_EN = 1'b1;
      cyc();
      for (int i = 0; i < 5; i++) begin
         PC_IN = 32'h600 + 32'(4 * i); INSTR_IN = 32'h13;
         cyc();
      end
      total++; if (COUNT !== 5'd5) begin bad++; $display("FAIL mid_pre got=%0d exp=5", COUNT); end
      OUT_READY = 1'b1; PC_IN = 32'h700; RESET = 1'b1;
      cyc();
      RESET = 1'b0; OUT_READY = 1'b0; PC_IN = 32'h704;
      total++; if (COUNT !== 5'd0 || OUT_VALID !== 1'b0 || DONE !== 1'b0) begin
         bad++; $display("FAIL mid_reset got=%0d/%b/%b exp=0/0/0", COUNT, OUT_VALID, DONE); end
      cyc();
      total++; if (COUNT !== 5'd0) begin bad++; $display("FAIL mid_idle got=%0d exp=0", COUNT); end
      cyc();
      total++; if (COUNT !== 5'd1 || OUT_DATA !== {32'h704, 32'h13}) begin
         bad++; $display("FAIL mid_capture got=%0d/%h exp=1/%h", COUNT, OUT_DATA, {32'h704, 32'h13}); end
      CAP_EN = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_dup();
      test_overflow();
      test_full_pop();
      test_halt();
      test_halt_drop();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cpu_trace_buffer.md
CPU_TRACE_BUFFER -- requirements
Module: cpu_trace_buffer

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entries (power of two, 2..256) SHALL be supported.
REQ-002 Parameter ADDR_W, default 4, SHALL equal log2(DEPTH).
REQ-003 Parameter HALT_INSTR, default 32'h0000006F (jal x0,0), SHALL define the end-of-program instruction.
REQ-004 CLK  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 RESET  input  1  synchronous, active-high reset.
REQ-006 CAP_EN  input  1  capture enable.
REQ-007 PC_IN  input  32  PC from the CPU debug port.
REQ-008 INSTR_IN  input  32  instruction from the CPU debug port.
REQ-009 OUT_VALID  output  1  head entry available.
REQ-010 OUT_READY  input  1  consumer accepts the head entry.
REQ-011 OUT_DATA  output  64  {pc[31:0], instr[31:0]} of the head entry.
REQ-012 COUNT  output  ADDR_W+1  occupied entries.
REQ-013 DROP_CNT  output  16  entries lost to overflow.
REQ-014 DONE  output  1  halt instruction captured.

Function
REQ-015 The FSM SHALL have the states IDLE, CAPTURE and HALTED.
REQ-016 IDLE SHALL go to CAPTURE when CAP_EN=1; no sample is taken in that cycle.
REQ-017 CAPTURE SHALL go to IDLE when CAP_EN=0 and no halt sample is taken in that cycle.
REQ-018 CAPTURE SHALL go to HALTED when a sample with INSTR_IN==HALT_INSTR is taken.
REQ-019 HALTED SHALL be left only by RESET, and CAP_EN SHALL be ignored in HALTED.
REQ-020 A sample SHALL be taken in CAPTURE when the first_flag is set or PC_IN differs from last_pc.
REQ-021 first_flag SHALL be set on every IDLE->CAPTURE transition and cleared by the first sample.
REQ-022 On every sample, last_pc SHALL load PC_IN.
REQ-023 A sample SHALL push {PC_IN, INSTR_IN} when COUNT<DEPTH, or when COUNT==DEPTH and a pop occurs in the same cycle.
REQ-024 A sample pushed under full-with-pop SHALL leave COUNT unchanged and SHALL NOT count as a drop.
REQ-025 A sample with COUNT==DEPTH and no pop SHALL be discarded.
REQ-026 A discarded sample SHALL increment DROP_CNT, saturating at 16'hFFFF.
REQ-027 A discarded halt sample SHALL still cause the transition to HALTED.
REQ-028 OUT_VALID SHALL equal (COUNT!=0).
REQ-029 OUT_DATA SHALL be the head entry, combinational from storage.
REQ-030 OUT_DATA SHALL be stable while OUT_VALID=1 and OUT_READY=0.
REQ-031 A pop SHALL occur when OUT_VALID && OUT_READY, and the pointer SHALL advance at that edge.
REQ-032 There SHALL be no fall-through: a pushed entry becomes visible on OUT_VALID/OUT_DATA on the cycle after its sample.
REQ-033 A simultaneous push and pop with COUNT==0 SHALL be impossible, since pop requires OUT_VALID; push only.
REQ-034 A simultaneous push and pop with 0<COUNT SHALL leave COUNT unchanged.
REQ-035 Read and write pointers SHALL be ADDR_W bits wide and wrap modulo DEPTH.
REQ-036 COUNT SHALL be tracked separately, so that full and empty are unambiguous.
REQ-037 Readout SHALL continue normally in IDLE and HALTED.
REQ-038 DONE SHALL be 1 exactly when the state is HALTED.

Reset
REQ-039 With RESET=1 at an edge, the state SHALL become IDLE.
REQ-040 With RESET=1 at an edge, the pointers and COUNT SHALL become 0, OUT_VALID 0, DROP_CNT 0, DONE 0, last_pc 0 and first_flag 1.
REQ-041 OUT_DATA SHALL be don't-care while OUT_VALID=0.
REQ-042 RESET SHALL override any simultaneous push, pop or transition, including mid-capture and in HALTED.
REQ-043 FIFO storage SHALL NOT require reset.

Verification
REQ-044 Basic capture: RESET pulse; CAP_EN=1; PC 0,4,8 with instr 13,93,113 on consecutive cycles; OUT_READY=0 -> COUNT 3; head {0,13} one cycle after first sample.
REQ-045 Duplicate suppression: PC held at 32'h10 for 5 cycles in CAPTURE -> exactly 1 entry.
REQ-046 Overflow: 20 distinct PCs with OUT_READY=0, DEPTH=16 -> COUNT 16, DROP_CNT 4; entries 0..15 read back in order.
REQ-047 Full with pop: COUNT=16, OUT_READY=1, new PC sampled -> COUNT stays 16, DROP_CNT unchanged, new entry is last out.
REQ-048 Halt: instr 32'h0000006F at PC 32'h24 -> entry {24,6F} stored, DONE=1 next cycle, further PCs ignored, drain completes; RESET -> DONE 0, COUNT 0.
REQ-049 Reset mid-operation: RESET asserted during simultaneous push/pop with COUNT=5 -> next cycle COUNT 0, OUT_VALID 0, state IDLE.
